// File: rtl/tog_hdlc_pkg.sv
// ============================================================================
// tog_hdlc_pkg : shared types and defaults for the toggle-coded HDLC receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package tog_hdlc_pkg;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic [7:0] FLAG_DEFAULT       = 8'h7E;
  localparam int         STUFF_ONES_DEFAULT = 5;
  localparam int         ABORT_ONES_DEFAULT = 7;
  // Holds the leading 0 and six 1s of a closing flag so they never reach the assembler.
  localparam int         PIPE_DEPTH         = 7;

endpackage

`default_nettype wire

// File: rtl/tog_decode.sv
// ============================================================================
// tog_decode : recovers data bits from a toggle-coded line (inverse T cell)
// Rev 1.0
// ============================================================================
`default_nettype none

module tog_decode
  import tog_hdlc_pkg::*;
#(
  parameter logic LINE_IDLE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic bit_en,
  output logic d_bit,
  output logic d_stb
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= LINE_IDLE;
    end else if (bit_en) begin
      r_prev <= line;
    end
  end

  assign d_bit = line ^ r_prev;
  assign d_stb = bit_en;

endmodule

`default_nettype wire

// File: rtl/tog_hdlc_rx.sv
// ============================================================================
// tog_hdlc_rx : toggle-decode, flag/abort detect, destuff and LSB-first bytes
// Rev 1.0
// ============================================================================
`default_nettype none

module tog_hdlc_rx
  import tog_hdlc_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter logic [7:0] FLAG       = FLAG_DEFAULT,
  parameter int         STUFF_ONES = STUFF_ONES_DEFAULT,
  parameter int         ABORT_ONES = ABORT_ONES_DEFAULT,
  parameter logic       LINE_IDLE  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line,
  input  logic              bit_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              align_err,
  output logic              abort_err
);

  localparam int c_ones_w = $clog2(ABORT_ONES + 1);
  localparam int c_cnt_w  = $clog2(DATA_W);
  localparam int c_fill_w = $clog2(PIPE_DEPTH + 1);

  localparam logic [c_ones_w-1:0] c_stuff = c_ones_w'(STUFF_ONES);
  localparam logic [c_ones_w-1:0] c_abort = c_ones_w'(ABORT_ONES);
  localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DATA_W - 1);
  localparam logic [c_fill_w-1:0] c_full  = c_fill_w'(PIPE_DEPTH);

  logic                  w_d;
  logic                  w_stb;
  logic [c_ones_w-1:0]   w_ones_nxt;
  logic [7:0]            w_win_nxt;
  logic                  w_flag;
  logic                  w_stuff;
  logic                  w_abort;
  logic                  w_full;
  logic                  w_out;
  logic [DATA_W-1:0]     w_byte;

  state_t                r_state;
  logic [c_ones_w-1:0]   r_ones;
  // The oldest window bit only matters on the cycle it is shifted out, so seven are stored.
  logic [6:0]            r_win;
  logic [PIPE_DEPTH-1:0] r_pipe;
  logic [c_fill_w-1:0]   r_fill;
  logic [DATA_W-2:0]     r_shift;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_got;

  tog_decode #(
    .LINE_IDLE(LINE_IDLE)
  ) u_decode (
    .clk   (clk),
    .reset (reset),
    .line  (line),
    .bit_en(bit_en),
    .d_bit (w_d),
    .d_stb (w_stb)
  );

  always_comb begin
    w_ones_nxt = '0;
    if (w_d) begin
      w_ones_nxt = (r_ones == c_abort) ? r_ones : r_ones + 1'b1;
    end
  end

  assign w_win_nxt = {w_d, r_win};
  assign w_flag    = (w_win_nxt == FLAG) && !w_d;
  assign w_stuff   = !w_d && (r_ones == c_stuff);
  assign w_abort   = (w_ones_nxt == c_abort);
  assign w_full    = (r_fill == c_full);
  assign w_out     = r_pipe[0];
  assign w_byte    = {w_out, r_shift};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_ones      <= '0;
      r_win       <= '0;
      r_pipe      <= '0;
      r_fill      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_got       <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      align_err   <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      align_err   <= 1'b0;
      abort_err   <= 1'b0;
      if (w_stb) begin
        r_ones <= w_ones_nxt;
        r_win  <= w_win_nxt[7:1];
        case (r_state)
          HUNT: begin
            if (w_flag) begin
              r_state     <= FRAME;
              frame_start <= 1'b1;
              r_fill      <= '0;
              r_cnt       <= '0;
              r_got       <= 1'b0;
            end
          end
          FRAME: begin
            if (w_abort) begin
              r_state   <= HUNT;
              abort_err <= 1'b1;
              r_fill    <= '0;
              r_cnt     <= '0;
              r_got     <= 1'b0;
            end else if (w_flag) begin
              // Closing flag doubles as the opening flag of the next frame.
              frame_end <= (r_cnt == '0) && r_got;
              align_err <= (r_cnt != '0);
              r_fill    <= '0;
              r_cnt     <= '0;
              r_got     <= 1'b0;
            end else if (!w_stuff) begin
              r_pipe <= {w_d, r_pipe[PIPE_DEPTH-1:1]};
              if (!w_full) begin
                r_fill <= r_fill + 1'b1;
              end else begin
                r_shift <= w_byte[DATA_W-1:1];
                if (r_cnt == c_last) begin
                  rx_data  <= w_byte;
                  rx_valid <= 1'b1;
                  r_cnt    <= '0;
                  r_got    <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tog_hdlc_rx.sv
// ============================================================================
// tb_tog_hdlc_rx : directed bench with a bit-stream reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tog_hdlc_rx;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       line   = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_start, frame_end, align_err, abort_err;

  int total = 0;
  int bad   = 0;

  tog_hdlc_rx dut (
    .clk        (clk),
    .reset      (reset),
    .line       (line),
    .bit_en     (bit_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .align_err  (align_err),
    .abort_err  (abort_err)
  );

  always #5 clk = ~clk;

  // Reference model: last eight raw bits, destuffed bits of the open frame.
  bit         m_hist[$];
  bit         m_fq[$];
  bit         m_in_frame;
  logic [7:0] e_data;
  bit         e_valid, e_fs, e_fe, e_ae, e_ab;

  bit         tx_lvl;
  int         tx_ones;

  logic [7:0] obs_q[$];
  int         n_fs, n_fe, n_ae, n_ab;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    m_fq.delete();
    m_in_frame = 1'b0;
    e_data = 8'h00;
    {e_valid, e_fs, e_fe, e_ae, e_ab} = 5'b0;
  endfunction

  function automatic void model_idle();
    {e_valid, e_fs, e_fe, e_ae, e_ab} = 5'b0;
  endfunction

  function automatic void model_bit(bit d);
    int         run;
    int         committed;
    bit         stuff, flag, abort_now;
    logic [7:0] win;
    model_idle();
    run = 0;
    for (int i = m_hist.size() - 1; i >= 0 && m_hist[i]; i--) run++;
    stuff = !d && (run == 5);
    m_hist.push_back(d);
    void'(m_hist.pop_front());
    run = d ? run + 1 : 0;
    for (int i = 0; i < 8; i++) win[i] = m_hist[i];
    flag      = (win == 8'h7E);
    abort_now = (run >= 7);
    if (!m_in_frame) begin
      if (flag) begin
        m_in_frame = 1'b1;
        e_fs = 1'b1;
        m_fq.delete();
      end
    end else if (abort_now) begin
      e_ab = 1'b1;
      m_in_frame = 1'b0;
      m_fq.delete();
    end else if (flag) begin
      // Seven of the queued bits belong to the flag itself.
      committed = m_fq.size() - 7;
      if (committed < 0) committed = 0;
      if (committed % 8 != 0) e_ae = 1'b1;
      else if (committed > 0) e_fe = 1'b1;
      m_fq.delete();
    end else if (!stuff) begin
      m_fq.push_back(d);
      if (m_fq.size() >= 15 && (m_fq.size() - 7) % 8 == 0) begin
        for (int i = 0; i < 8; i++) e_data[i] = m_fq[m_fq.size() - 15 + i];
        e_valid = 1'b1;
      end
    end
  endfunction

  task automatic drive(bit en, bit ln, bit d);
    @(negedge clk);
    bit_en = en;
    line   = ln;
    if (en) model_bit(d);
    else    model_idle();
  endtask

  task automatic send_raw(bit d, int gap);
    repeat (gap) drive(1'b0, 1'($urandom), 1'b0);
    tx_lvl = tx_lvl ^ d;
    drive(1'b1, tx_lvl, d);
  endtask

  task automatic send_data(bit b, int gap);
    send_raw(b, gap);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_raw(1'b0, gap);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(logic [7:0] v, int gap);
    for (int i = 0; i < 8; i++) send_data(v[i], gap);
  endtask

  task automatic send_flag(int gap);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_raw(f[i], gap);
    tx_ones = 0;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, tx_lvl, 1'b0);
  endtask

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_byte(string name, int idx, int want);
    check(name, (idx < obs_q.size()) ? int'(obs_q[idx]) : -1, want);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    n_fs = 0; n_fe = 0; n_ae = 0; n_ab = 0;
  endtask

  initial begin : cmp
    logic [12:0] want, got;
    forever begin
      @(posedge clk);
      want = {e_data, e_valid, e_fs, e_fe, e_ae, e_ab};
      #1;
      got = {rx_data, rx_valid, frame_start, frame_end, align_err, abort_err};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, got, want);
      end
      if (rx_valid) obs_q.push_back(rx_data);
      n_fs += int'(frame_start);
      n_fe += int'(frame_end);
      n_ae += int'(align_err);
      n_ab += int'(abort_err);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    tx_lvl = 1'b0;
    tx_ones = 0;
    clear_obs();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_pulses", int'({rx_valid, frame_start, frame_end, align_err, abort_err}), 0);
    reset = 1'b1;

    // Idle-flag lock
    clear_obs();
    send_flag(0); send_byte(8'hA5, 0); send_flag(0); idle(4);
    check("t1_fs", n_fs, 1);
    check("t1_nbytes", obs_q.size(), 1);
    check_byte("t1_byte0", 0, 8'hA5);
    check("t1_fe", n_fe, 1);

    // Destuffing: previous closing flag opens this frame
    clear_obs();
    send_byte(8'hFF, 0); send_flag(0); idle(4);
    check("t2_nbytes", obs_q.size(), 1);
    check_byte("t2_byte0", 0, 8'hFF);
    check("t2_abort", n_ab, 0);
    check("t2_fe", n_fe, 1);

    // Multi-byte, one bit every third cycle
    clear_obs();
    send_flag(2); send_byte(8'h01, 2); send_byte(8'h02, 2); send_byte(8'h03, 2);
    send_flag(2); idle(6);
    check("t3_nbytes", obs_q.size(), 3);
    check_byte("t3_byte0", 0, 8'h01);
    check_byte("t3_byte1", 1, 8'h02);
    check_byte("t3_byte2", 2, 8'h03);
    check("t3_fe", n_fe, 1);
    check("t3_fs", n_fs, 0);

    // Abort
    clear_obs();
    send_flag(0);
    send_data(1'b0, 0); send_data(1'b1, 0); send_data(1'b0, 0);
    send_data(1'b1, 0); send_data(1'b0, 0);
    repeat (7) send_raw(1'b1, 0);
    idle(3);
    check("t4_abort", n_ab, 1);
    check("t4_nbytes", obs_q.size(), 0);
    check("t4_fs_before", n_fs, 0);
    send_flag(0); idle(3);
    check("t4_fs_after", n_fs, 1);

    // Alignment error
    clear_obs();
    send_flag(0); send_byte(8'h5A, 0);
    send_data(1'b1, 0); send_data(1'b0, 0); send_data(1'b1, 0); send_data(1'b1, 0);
    send_flag(0); idle(4);
    check("t5_nbytes", obs_q.size(), 1);
    check_byte("t5_byte0", 0, 8'h5A);
    check("t5_ae", n_ae, 1);
    check("t5_fe", n_fe, 0);

    // Reset mid-frame
    clear_obs();
    send_flag(0);
    send_data(1'b1, 0); send_data(1'b1, 0); send_data(1'b0, 0); send_data(1'b1, 0);
    @(negedge clk);
    reset = 1'b0;
    bit_en = 1'b0;
    line = 1'b0;
    model_reset();
    tx_lvl = 1'b0;
    tx_ones = 0;
    #1;
    check("t6_rst_rx_data", int'(rx_data), 0);
    check("t6_rst_pulses", int'({rx_valid, frame_start, frame_end, align_err, abort_err}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_flag(0); send_byte(8'h3C, 0); send_flag(0); idle(4);
    check("t6_fs", n_fs, 1);
    check("t6_nbytes", obs_q.size(), 1);
    check_byte("t6_byte0", 0, 8'h3C);
    check("t6_fe", n_fe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tog_hdlc_rx.md
Name: tog_hdlc_rx

Overview:
- Receive end of the team's toggle-coded serial link. The line toggles for each '1' and holds its level for each '0', which is T flip-flop semantics.
- Decodes each sample back to a bit, removes HDLC-style stuffed zeros, detects 8'h7E flags and aborts, and assembles LSB-first bytes.
- Sits between the line synchroniser/bit-strobe generator and the byte-wide frame consumer.

Parameters:
- DATA_W, 8, assembled word width.
- FLAG, 8'h7E, frame delimiter pattern, matched on raw decoded bits.
- STUFF_ONES, 5: after this many consecutive 1s, the following 0 is discarded.
- ABORT_ONES, 7: this many consecutive 1s is an abort.
- LINE_IDLE, 1'b0: reset value of the previous-level register.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; all state clears while reset=0.
- line  in  1  synchronised toggle-coded line level.
- bit_en  in  1  one-cycle strobe; line is sampled only when bit_en=1.
- rx_data  out  DATA_W  assembled byte; holds its value between rx_valid pulses.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- frame_start  out  1  one-cycle pulse, opening flag accepted.
- frame_end  out  1  one-cycle pulse, closing flag after at least one byte.
- align_err  out  1  one-cycle pulse, closing flag with partial byte pending.
- abort_err  out  1  one-cycle pulse, abort detected inside a frame.

Behaviour:
- Reset values:
  - rx_data=0; all pulse outputs 0.
  - prev=LINE_IDLE, state=HUNT, ones counter=0, raw window=0, pipe empty, bit count=0.
- Decode, on bit_en only: d = line XOR prev; prev <= line. Without bit_en, no internal state changes.
- Ones counter:
  - d=1: counter increments, saturating at ABORT_ONES.
  - d=0: counter clears.
- Raw window: 8-bit shift register fed with d, newest bit at MSB. A flag is matched when the window == FLAG and the current d=0.
- Destuff: a d=0 arriving when the counter == STUFF_ONES is dropped from the data path. It still enters the raw window and still clears the counter.
- Holding pipe:
  - 7-bit delay with a fill count for destuffed bits. It covers the leading 0 plus six 1s of a closing flag.
  - A bit leaving the pipe enters the byte assembler, LSB first.
  - While the pipe is not full, bits only fill it.
- States:
  - HUNT: data path idle. Flag match -> FRAME, frame_start=1, pipe and assembler cleared.
  - FRAME, flag match:
    - Pipe is discarded.
    - If assembler bit count==0 and at least one byte was delivered this frame: frame_end=1.
    - If bit count != 0: align_err=1.
    - In both cases, stay in FRAME, treat the flag as the opening flag of the next frame, and do not pulse frame_start again.
    - Back-to-back flags with no data produce no pulses.
  - Abort: the counter reaching ABORT_ONES in FRAME gives abort_err=1, -> HUNT, pipe and assembler cleared. The same condition in HUNT is silent.
- Byte out: on the bit_en cycle that moves the DATA_W-th bit into the assembler, rx_data and rx_valid update on that clock edge, so they are visible the following cycle. Bit count wraps to 0.
- Simultaneous events: flag match and byte completion cannot coincide, because the pipe absorbs the flag bits. Abort has priority over any pending byte, and that byte is discarded.
- Reset mid-frame: immediate return to reset values; no pulses.

Decomposition:
- Package tog_hdlc_pkg holds:
  - state enum {HUNT, FRAME}.
  - FLAG_DEFAULT=8'h7E, STUFF_ONES_DEFAULT=5, ABORT_ONES_DEFAULT=7.
- One sub-module, tog_decode: prev register plus XOR, giving the decoded bit and a qualified strobe. It is the inverse of the team's T-from-D toggle cell.

Test Plan:
- Idle-flag lock: flag 7E, byte A5, then flag, toggle-encoded. Expect frame_start after the first flag, one rx_valid with rx_data=8'hA5, then frame_end.
- Destuffing: payload FF, sent as 11111 0 111 with the 0 stuffed, between flags. Expect exactly one byte 8'hFF and no abort.
- Multi-byte frame with bit_en duty 1/3: flag, 01 02 03, flag. Expect three rx_valid pulses in order 01, 02, 03, each one cycle wide, then frame_end.
- Abort: flag, 5 data bits, then 7 consecutive 1s. Expect abort_err=1, no rx_valid, state HUNT. A subsequent flag gives frame_start again.
- Alignment error: flag, 12 data bits, flag. Expect one rx_valid, then align_err=1 and no frame_end.
- Reset mid-frame: assert reset=0 after 4 payload bits. All outputs go 0 immediately. After release, the bench sends a flag then 8'h3C and expects 8'h3C.
